mema_read_sequencer: RTL and testbench

MEMA_READ_SEQUENCER -- requirements
Module: mema_read_sequencer

---
 rtl/mema_read_sequencer.sv | 172 +++++++++++++++++
 tb/tb_mema_read_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mema_read_sequencer.sv
// mema_read_sequencer
//
// Streams a block of memA rows to a bank of row-by-vector modules. For each
// row it pulses read_preprocess with the row address, waits long enough for
// the memA chunk counters to run through the longest module segment, then
// waits until every consumer reports ready before issuing the next row.
//
// Ports
//   clk                 rising-edge clock
//   reset_n             asynchronous active-low reset
//   start               one-cycle pulse; accepted only while idle
//   start_address[31:0] memA address of the first row
//   no_of_rows[31:0]    number of rows in the run (0 finishes at once)
//   row_lengths         per-module element counts, module m at [32*(m+1)-1 -: 32]
//   I_am_ready          per-module consumer ready flags
//   memA_read_address   row address presented to memA
//   read_preprocess     one-cycle strobe starting the memA chunk counters
//   no_of_multiples     per-module chunk counts, same packing as row_lengths
//   busy                high from start acceptance until the done cycle
//   done                one-cycle end-of-run pulse
module mema_read_sequencer #(
  parameter int no_of_row_by_vector_modules = 4,
  parameter int no_of_units                 = 8,   // must be a power of two
  parameter int no_of_elements_on_col_nos   = 20
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic                                      start,
  input  logic [31:0]                               start_address,
  input  logic [31:0]                               no_of_rows,
  input  logic [32*no_of_row_by_vector_modules-1:0] row_lengths,
  input  logic [no_of_row_by_vector_modules-1:0]    I_am_ready,
  output logic [31:0]                               memA_read_address,
  output logic                                      read_preprocess,
  output logic [32*no_of_row_by_vector_modules-1:0] no_of_multiples,
  output logic                                      busy,
  output logic                                      done
);

  localparam int          N          = no_of_row_by_vector_modules;
  localparam int          unit_shift = $clog2(no_of_units);
  localparam logic [31:0] unit_mask  = 32'(no_of_units - 1);
  localparam logic [31:0] max_len    = 32'(no_of_elements_on_col_nos);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    STREAM,
    WAIT_READY,
    FINISH
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         start_q;
  logic [31:0]         rows_q;
  logic [32*N-1:0]     len_q;
  logic [31:0]         row_cnt_q;
  logic [31:0]         stream_cnt_q;
  logic [31:0]         addr_q;
  logic [32*N-1:0]     mult_q;
  logic [31:0]         max_mult_q;

  logic [32*N-1:0]     mult_calc;
  logic [31:0]         max_calc;
  logic [31:0]         stream_last;
  logic                all_ready;
  logic                last_row;

  // Chunks needed for one module segment: ceil(len/no_of_units), with the
  // length clamped to the segment capacity. An empty segment still costs one
  // chunk step in the memA counters, hence the floor of 1.
  function automatic logic [31:0] chunks(input logic [31:0] len);
    logic [31:0] eff;
    eff = (len > max_len) ? max_len : len;
    if (eff == 32'd0) return 32'd1;
    return (eff >> unit_shift) + {31'd0, |(eff & unit_mask)};
  endfunction

  // NOTE: every variable assigned in an always_comb gets a default at the top
  // of the block, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    mult_calc = '0;
    max_calc  = '0;
    for (int m = 0; m < N; m++) begin
      mult_calc[32*m +: 32] = chunks(len_q[32*m +: 32]);
      if (mult_calc[32*m +: 32] > max_calc) max_calc = mult_calc[32*m +: 32];
    end
  end

  // STREAM occupies 2*max_mult+2 cycles; the counter starts at 0.
  assign stream_last = {max_mult_q[30:0], 1'b0} + 32'd1;
  assign all_ready   = &I_am_ready;
  assign last_row    = (row_cnt_q == rows_q - 32'd1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (start) state_d = LOAD;
      LOAD:       state_d = (rows_q == 32'd0) ? FINISH : ISSUE;
      ISSUE:      state_d = STREAM;
      STREAM:     if (stream_cnt_q == stream_last) state_d = WAIT_READY;
      WAIT_READY: if (all_ready) state_d = last_row ? FINISH : ISSUE;
      FINISH:     state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_q      <= '0;
      rows_q       <= '0;
      len_q        <= '0;
      row_cnt_q    <= '0;
      stream_cnt_q <= '0;
      addr_q       <= '0;
      mult_q       <= '0;
      max_mult_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            start_q <= start_address;
            rows_q  <= no_of_rows;
            len_q   <= row_lengths;
          end
        end
        LOAD: begin
          // Chunk counts are written only here, so they hold until the next
          // accepted run reaches LOAD again.
          mult_q     <= mult_calc;
          max_mult_q <= max_calc;
          row_cnt_q  <= '0;
          if (rows_q != 32'd0) addr_q <= start_q;
        end
        ISSUE: begin
          stream_cnt_q <= '0;
        end
        STREAM: begin
          stream_cnt_q <= stream_cnt_q + 32'd1;
        end
        WAIT_READY: begin
          // The address register is loaded on the way into ISSUE so it is
          // already valid while read_preprocess is high. 32-bit wrap intended.
          if (all_ready && !last_row) begin
            row_cnt_q <= row_cnt_q + 32'd1;
            addr_q    <= start_q + row_cnt_q + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign memA_read_address = addr_q;
  assign no_of_multiples   = mult_q;
  assign read_preprocess   = (state_q == ISSUE);
  assign done              = (state_q == FINISH);
  assign busy              = (state_q == LOAD) || (state_q == ISSUE) ||
                             (state_q == STREAM) || (state_q == WAIT_READY);

endmodule

// File: tb/tb_mema_read_sequencer.sv
// Testbench for mema_read_sequencer: directed runs, with a scoreboard queue of
// expected read_preprocess / done events checked by an independent monitor.
module tb_mema_read_sequencer;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            start;
  logic [31:0]     start_address;
  logic [31:0]     no_of_rows;
  logic [32*N-1:0] row_lengths;
  logic [N-1:0]    I_am_ready;
  logic [31:0]     memA_read_address;
  logic            read_preprocess;
  logic [32*N-1:0] no_of_multiples;
  logic            busy;
  logic            done;

  mema_read_sequencer #(
    .no_of_row_by_vector_modules(N),
    .no_of_units(8),
    .no_of_elements_on_col_nos(20)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .start_address     (start_address),
    .no_of_rows        (no_of_rows),
    .row_lengths       (row_lengths),
    .I_am_ready        (I_am_ready),
    .memA_read_address (memA_read_address),
    .read_preprocess   (read_preprocess),
    .no_of_multiples   (no_of_multiples),
    .busy              (busy),
    .done              (done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit              is_done;
    int unsigned     cyc;
    logic [31:0]     addr;
    logic [32*N-1:0] nom;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  localparam logic [127:0] LEN_20  = {32'd20, 32'd20, 32'd20, 32'd20};
  localparam logic [127:0] NOM_333 = {32'd3, 32'd3, 32'd3, 32'd3};
  localparam logic [127:0] NOM_111 = {32'd1, 32'd1, 32'd1, 32'd1};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every DUT event must match the head of the expected queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && (read_preprocess === 1'b1 || done === 1'b1)) begin
        if (q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_event: got rp=%0b done=%0b addr=%0h at cycle %0d, expected no event",
                   read_preprocess, done, memA_read_address, cyc);
        end else begin
          e = q.pop_front();
          check("event_kind", {127'd0, done}, {127'd0, e.is_done});
          check("event_cycle", 128'(cyc), 128'(e.cyc));
          if (!e.is_done) begin
            check("rp_address", 128'(memA_read_address), 128'(e.addr));
            check("rp_multiples", no_of_multiples, e.nom);
            check("rp_busy", {127'd0, busy}, 128'd1);
          end else begin
            check("done_busy", {127'd0, busy}, 128'd0);
          end
        end
      end
    end
  end

  task automatic start_run(input logic [31:0] a, input logic [31:0] r,
                           input logic [127:0] l, output int unsigned s);
    @(negedge clk);
    start_address = a;
    no_of_rows    = r;
    row_lengths   = l;
    start         = 1'b1;
    s             = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Expected events for a run with every consumer ready: row i issues at
  // start+2+i*spacing, done follows the last WAIT_READY cycle.
  task automatic push_run(input int unsigned s, input logic [31:0] a, input int rows,
                          input logic [127:0] nom, input int sp);
    exp_t e;
    for (int i = 0; i < rows; i++) begin
      e.is_done = 1'b0;
      e.cyc     = s + 2 + i * sp;
      e.addr    = a + 32'(i);
      e.nom     = nom;
      q.push_back(e);
    end
    e.is_done = 1'b1;
    e.cyc     = s + 2 + rows * sp;
    e.addr    = '0;
    e.nom     = '0;
    q.push_back(e);
  endtask

  task automatic push_one(input bit d, input int unsigned c, input logic [31:0] a,
                          input logic [127:0] nom);
    exp_t e;
    e.is_done = d;
    e.cyc     = c;
    e.addr    = a;
    e.nom     = nom;
    q.push_back(e);
  endtask

  task automatic wait_until(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain_timeout: got %0d pending events, expected 0", q.size());
      q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned s;

    reset_n       = 1'b0;
    start         = 1'b0;
    start_address = '0;
    no_of_rows    = '0;
    row_lengths   = '0;
    I_am_ready    = 4'hF;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_addr", 128'(memA_read_address), 128'd0);
    check("rst_rp", {127'd0, read_preprocess}, 128'd0);
    check("rst_nom", no_of_multiples, 128'd0);
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_done", {127'd0, done}, 128'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", {127'd0, busy}, 128'd0);

    // Basic run; a start while busy and a start in the done cycle are ignored.
    start_run(32'h10, 32'd3, LEN_20, s);
    push_run(s, 32'h10, 3, NOM_333, 10);
    wait_until(s + 5);
    start_address = 32'h999;
    no_of_rows    = 32'd1;
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(s + 8);
    check("busy_start_addr", 128'(memA_read_address), 128'h10);
    wait_until(s + 32);
    start_address = 32'h55;
    no_of_rows    = 32'd1;
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain(60);
    repeat (12) @(negedge clk);
    check("done_start_ignored_busy", {127'd0, busy}, 128'd0);
    check("done_start_ignored_addr", 128'(memA_read_address), 128'h12);

    // Ragged lengths: modules 3..0 = 0,8,9,17 -> chunks 1,1,2,3.
    start_run(32'h100, 32'd2, {32'd0, 32'd8, 32'd9, 32'd17}, s);
    push_run(s, 32'h100, 2, {32'd1, 32'd1, 32'd2, 32'd3}, 10);
    drain(60);

    // All single-chunk modules: spacing 2*1+4 = 6.
    start_run(32'h200, 32'd3, {32'd1, 32'd8, 32'd0, 32'd5}, s);
    push_run(s, 32'h200, 3, NOM_111, 6);
    drain(60);

    // Saturation above 20 elements -> 3 chunks; 16 -> 2.
    start_run(32'h300, 32'd1, {32'd100, 32'd21, 32'd20, 32'd16}, s);
    push_run(s, 32'h300, 1, {32'd3, 32'd3, 32'd3, 32'd2}, 10);
    drain(60);

    // Zero rows: done two cycles after start, no read_preprocess.
    start_run(32'h400, 32'd0, LEN_20, s);
    push_one(1'b1, s + 2, '0, '0);
    drain(20);

    // Address wrap past 0xFFFFFFFF.
    start_run(32'hFFFF_FFFF, 32'd2, {32'd8, 32'd8, 32'd8, 32'd8}, s);
    push_run(s, 32'hFFFF_FFFF, 2, NOM_111, 6);
    drain(60);

    // Ready stall: partial ready for 5 WAIT_READY cycles of the first row.
    I_am_ready = 4'b1011;
    start_run(32'h10, 32'd3, LEN_20, s);
    push_one(1'b0, s + 2,  32'h10, NOM_333);
    push_one(1'b0, s + 17, 32'h11, NOM_333);
    push_one(1'b0, s + 27, 32'h12, NOM_333);
    push_one(1'b1, s + 37, '0, '0);
    wait_until(s + 15);
    check("stall_addr", 128'(memA_read_address), 128'h10);
    check("stall_busy", {127'd0, busy}, 128'd1);
    wait_until(s + 16);
    I_am_ready = 4'hF;
    drain(60);

    // Reset in the middle of STREAM aborts the run without done.
    start_run(32'h40, 32'd3, LEN_20, s);
    push_one(1'b0, s + 2, 32'h40, NOM_333);
    wait_until(s + 5);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_rp", {127'd0, read_preprocess}, 128'd0);
    check("midrst_done", {127'd0, done}, 128'd0);
    check("midrst_busy", {127'd0, busy}, 128'd0);
    check("midrst_addr", 128'(memA_read_address), 128'd0);
    check("midrst_nom", no_of_multiples, 128'd0);
    check("midrst_sb_empty", 128'(q.size()), 128'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check("post_rst_idle", {127'd0, busy}, 128'd0);

    // Fresh start after reset works normally.
    start_run(32'h80, 32'd1, LEN_20, s);
    push_run(s, 32'h80, 1, NOM_333, 10);
    drain(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
